// File: rtl/memory_access_if.sv
// rtl/memory_access_if.sv - data-memory request/ready port between the MEM stage and memory
interface memory_access_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      req;
    logic                      we;
    logic [DATA_WIDTH-1:0]     addr;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/memory_access.sv
// rtl/memory_access.sv - RV32I MEM stage: aligned loads/stores over req/ready, MEM/WB register, stall
module memory_access #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR       = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  i_ex_mem_to_reg,
    input  logic                  i_ex_reg_wr,
    input  logic                  i_ex_mem_rd,
    input  logic                  i_ex_mem_wr,
    input  logic                  i_ex_result_src,
    input  logic [DATA_WIDTH-1:0] i_ex_alu_result,
    input  logic [DATA_WIDTH-1:0] i_ex_data2,
    input  logic [DATA_WIDTH-1:0] i_ex_pc_plus_4,
    input  logic [REG_ADDR-1:0]   i_ex_reg_destination,
    input  logic [2:0]            i_ex_funct3,
    memory_access_if.master       dmem,
    output logic                  o_mem_stall,
    output logic                  o_mem_misaligned,
    output logic                  o_mem_bus_err,
    output logic                  o_mem_reg_wr,
    output logic                  o_mem_mem_to_reg,
    output logic                  o_mem_result_src,
    output logic [DATA_WIDTH-1:0] o_mem_alu_result,
    output logic [DATA_WIDTH-1:0] o_mem_read_data,
    output logic [DATA_WIDTH-1:0] o_mem_pc_plus_4,
    output logic [REG_ADDR-1:0]   o_mem_reg_destination
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_t;

    typedef struct packed {
        logic                  reg_wr;
        logic                  mem_to_reg;
        logic                  result_src;
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] read_data;
        logic [DATA_WIDTH-1:0] pc_plus_4;
        logic [REG_ADDR-1:0]   rd;
    } wb_t;

    // Everything needed to keep driving and later retire an outstanding access.
    typedef struct packed {
        logic                  we;
        logic [2:0]            funct3;
        logic [3:0]            be;
        logic [DATA_WIDTH-1:0] wdata;
        wb_t                   ctrl;
    } pend_t;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   lane_be = 4'b0001 << a;
            2'b01:   lane_be = 4'b0011 << {a[1], 1'b0};
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic [1:0] size,
                                                         input logic [DATA_WIDTH-1:0] d);
        case (size)
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                          input logic [1:0] a,
                                                          input logic [DATA_WIDTH-1:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'b00:   b = r[7:0];
            2'b01:   b = r[15:8];
            2'b10:   b = r[23:16];
            default: b = r[31:24];
        endcase
        h = a[1] ? r[31:16] : r[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'b0, b};
            3'b101:  load_extend = {16'b0, h};
            default: load_extend = r;
        endcase
    endfunction

    // Retire an access: stores never write rd, loads carry the extended word.
    function automatic wb_t complete(input pend_t p, input logic [DATA_WIDTH-1:0] r);
        wb_t w;
        w = p.ctrl;
        if (p.we) begin
            w.reg_wr    = 1'b0;
            w.read_data = '0;
        end else begin
            w.read_data = load_extend(p.funct3, p.ctrl.alu_result[1:0], r);
        end
        return w;
    endfunction

    state_t         state_q, state_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    pend_t          pend_q, pend_d;
    wb_t            wb_q, wb_d;

    wb_t    ex_wb;
    pend_t  ex_pend;
    pend_t  cur;
    logic   ex_access;
    logic   ex_misaligned;
    logic   req;

    // Repackage the EX/MEM bundle into the same shapes used by the latched copy.
    always_comb begin
        ex_wb            = '0;
        ex_wb.reg_wr     = i_ex_reg_wr;
        ex_wb.mem_to_reg = i_ex_mem_to_reg;
        ex_wb.result_src = i_ex_result_src;
        ex_wb.alu_result = i_ex_alu_result;
        ex_wb.pc_plus_4  = i_ex_pc_plus_4;
        ex_wb.rd         = i_ex_reg_destination;

        ex_pend          = '0;
        ex_pend.we       = i_ex_mem_wr;
        ex_pend.funct3   = i_ex_funct3;
        ex_pend.be       = lane_be(i_ex_funct3[1:0], i_ex_alu_result[1:0]);
        ex_pend.wdata    = lane_wdata(i_ex_funct3[1:0], i_ex_data2);
        ex_pend.ctrl     = ex_wb;

        ex_access        = i_ex_mem_rd | i_ex_mem_wr;
        ex_misaligned    = ((i_ex_funct3[1:0] == 2'b01) && i_ex_alu_result[0]) ||
                           (i_ex_funct3[1] && (i_ex_alu_result[1:0] != 2'b00));
    end

    // Access FSM: next state, bus request, stall/pulse outputs and next MEM/WB contents.
    always_comb begin
        state_d          = state_q;
        wait_cnt_d       = wait_cnt_q;
        pend_d           = pend_q;
        wb_d             = wb_q;
        req              = 1'b0;
        cur              = ex_pend;
        o_mem_stall      = 1'b0;
        o_mem_misaligned = 1'b0;
        o_mem_bus_err    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clk_en && ex_access) begin
                    if (ex_misaligned) begin
                        o_mem_misaligned = 1'b1;
                        wb_d             = ex_wb;
                        wb_d.reg_wr      = 1'b0;
                    end else begin
                        req = 1'b1;
                        if (dmem.ready) begin
                            wb_d = complete(ex_pend, dmem.rdata);
                        end else begin
                            o_mem_stall = 1'b1;
                            pend_d      = ex_pend;
                            wait_cnt_d  = '0;
                            state_d     = ST_WAIT;
                            wb_d        = '0;
                        end
                    end
                end else if (clk_en) begin
                    wb_d = ex_wb;
                end
            end
            ST_WAIT: begin
                cur         = pend_q;
                req         = 1'b1;
                o_mem_stall = 1'b1;
                if (clk_en) begin
                    if (dmem.ready) begin
                        o_mem_stall = 1'b0;
                        wb_d        = complete(pend_q, dmem.rdata);
                        state_d     = ST_IDLE;
                    end else if (wait_cnt_q == LAST_WAIT) begin
                        o_mem_stall   = 1'b0;
                        o_mem_bus_err = 1'b1;
                        wb_d          = pend_q.ctrl;
                        wb_d.reg_wr   = 1'b0;
                        state_d       = ST_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                        wb_d       = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dmem.req   = req;
    assign dmem.we    = req & cur.we;
    assign dmem.addr  = req ? {cur.ctrl.alu_result[DATA_WIDTH-1:2], 2'b00} : '0;
    assign dmem.be    = req ? cur.be : 4'b0000;
    assign dmem.wdata = req ? cur.wdata : '0;

    // State, wait counter, pending access and MEM/WB register; clk_en freezes all of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            pend_q     <= '0;
            wb_q       <= '0;
        end else if (clk_en) begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            pend_q     <= pend_d;
            wb_q       <= wb_d;
        end
    end

    assign o_mem_reg_wr          = wb_q.reg_wr;
    assign o_mem_mem_to_reg      = wb_q.mem_to_reg;
    assign o_mem_result_src      = wb_q.result_src;
    assign o_mem_alu_result      = wb_q.alu_result;
    assign o_mem_read_data       = wb_q.read_data;
    assign o_mem_pc_plus_4       = wb_q.pc_plus_4;
    assign o_mem_reg_destination = wb_q.rd;

endmodule
